// File: rtl/axi_sample_burst_master.sv
// AXI4 INCR write-burst master that drains a 16-bit sample FIFO into sequential byte addresses.
// Define AXI_MASTER_TIMEOUT_EN to add a B-response watchdog that aborts the frame.
module axi_sample_burst_master #(
  parameter int unsigned ID_W_WIDTH  = 2,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned AWID_VAL    = 0,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [11:0]           i_SAMPLES_NUMBER,
  input  logic [15:0]           i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [11:0]           o_AWADDR,
  output logic [7:0]            o_AWLEN,
  output logic [2:0]            o_AWSIZE,
  output logic [1:0]            o_AWBURST,
  output logic [ID_W_WIDTH-1:0] o_AWID,
  output logic                  o_AWVALID,
  input  logic                  i_AWREADY,
  output logic [15:0]           o_WDATA,
  output logic [1:0]            o_WSTRB,
  output logic                  o_WVALID,
  output logic                  o_WLAST,
  input  logic                  i_WREADY,
  input  logic                  i_BVALID,
  input  logic [ID_W_WIDTH-1:0] i_BID,
  output logic                  o_BREADY,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < BURST_LEN || BURST_LEN == 0 || BURST_LEN > 16 || TIMEOUT_CYC == 0)
  begin : g_bad_cfg
    $error("axi_sample_burst_master: invalid parameter set");
  end

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  state_t state;

  logic [15:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, fifo_cnt;
  logic [11:0] total, issued, pushed, remaining, beats;
  logic [7:0]  beat_cnt;
  logic        push, pop;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
`endif

  function automatic logic [11:0] beats_of(input logic [11:0] rem);
    return (rem > 12'(BURST_LEN)) ? 12'(BURST_LEN) : rem;
  endfunction

  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign remaining = total - issued;
  assign beats     = beats_of(remaining);

  assign o_busy    = (state == ADDR) || (state == DATA) || (state == RESP);
  assign o_done    = (state == DONE);
  // Stop accepting once the whole frame has entered the FIFO; the MSB of the count means full.
  assign o_s_ready = o_busy && !fifo_cnt[PW] && (pushed != total);
  assign push      = i_s_valid && o_s_ready;
  assign pop       = o_WVALID && i_WREADY;

  assign o_AWSIZE  = 3'b001;
  assign o_AWBURST = 2'b01;
  assign o_WSTRB   = 2'b11;
  assign o_AWID    = ID_W_WIDTH'(AWID_VAL);
  assign o_WDATA   = o_WVALID ? mem[rd_ptr[PW-1:0]] : '0;
  assign o_WLAST   = o_WVALID && (beat_cnt == o_AWLEN);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= i_s_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      total     <= '0;
      issued    <= '0;
      pushed    <= '0;
      beat_cnt  <= '0;
      o_AWADDR  <= '0;
      o_AWLEN   <= '0;
      o_AWVALID <= 1'b0;
      o_WVALID  <= 1'b0;
      o_BREADY  <= 1'b0;
      o_error   <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pushed <= pushed + 12'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE: if (i_start) begin
          o_error  <= 1'b0;
          total    <= i_SAMPLES_NUMBER;
          issued   <= '0;
          pushed   <= '0;
          o_AWADDR <= '0;
          o_AWLEN  <= (i_SAMPLES_NUMBER == '0) ? '0 : 8'(beats_of(i_SAMPLES_NUMBER) - 12'd1);
          state    <= (i_SAMPLES_NUMBER == '0) ? DONE : ADDR;
        end
        // AWVALID waits for a full burst in the FIFO so W can never starve mid-burst.
        ADDR: if (o_AWVALID && i_AWREADY) begin
          o_AWVALID <= 1'b0;
          o_WVALID  <= 1'b1;
          issued    <= issued + beats;
          beat_cnt  <= '0;
          state     <= DATA;
        end else if (12'(fifo_cnt) >= beats) begin
          o_AWVALID <= 1'b1;
        end
        DATA: if (pop) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (o_WLAST) begin
            o_WVALID <= 1'b0;
            o_BREADY <= 1'b1;
            state    <= RESP;
`ifdef AXI_MASTER_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        // issued already includes this burst, so beats here is the size of the next one.
        RESP: begin
          if (i_BVALID) begin
            o_BREADY <= 1'b0;
            if (i_BID != o_AWID) o_error <= 1'b1;
            if (remaining == '0) begin
              state <= DONE;
            end else begin
              o_AWADDR <= {issued[10:0], 1'b0};
              o_AWLEN  <= 8'(beats - 12'd1);
              state    <= ADDR;
            end
          end
`ifdef AXI_MASTER_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            o_BREADY <= 1'b0;
            o_error  <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            state    <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
